// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store engine.
// Runs a req/ack data-bus transaction for loads and stores, formats load data
// with sign/zero extension and stalls the pipeline while the access is
// outstanding. Non-memory ops pass straight through.
// Optional feature: define MEM_TIMEOUT_EN to abort a bus cycle that sees no
// ack within TIMEOUT_CYCLES BUSY cycles (bus_err_o pulses, write suppressed).

`ifndef MEM_ACCESS_DEFS
`define MEM_ACCESS_DEFS
`define AluOpBus    7:0
`define RegBus      31:0
`define RegAddrBus  4:0
`define EXE_NOP_OP  8'b00000000
`define EXE_ADD_OP  8'b00100000
`define EXE_LB_OP   8'b11100000
`define EXE_LH_OP   8'b11100001
`define EXE_LW_OP   8'b11100011
`define EXE_LBU_OP  8'b11100100
`define EXE_LHU_OP  8'b11100101
`define EXE_SB_OP   8'b11101000
`define EXE_SH_OP   8'b11101001
`define EXE_SW_OP   8'b11101011
`endif

module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [`AluOpBus]   aluop_i,
  input  logic [`RegBus]     mem_addr_i,
  input  logic [`RegBus]     reg2_i,
  input  logic [`RegAddrBus] wd_i,
  input  logic               wreg_i,
  input  logic [`RegBus]     wdata_i,
  output logic [`RegAddrBus] wd_o,
  output logic               wreg_o,
  output logic [`RegBus]     wdata_o,
  output logic               stall_o,
  output logic               misalign_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [`RegBus]     bus_addr_o,
  output logic [3:0]         bus_sel_o,
  output logic [`RegBus]     bus_wdata_o,
  input  logic [`RegBus]     bus_rdata_i,
  input  logic               bus_ack_i,
  output logic               bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_n;
  logic         is_byte, is_half, is_word, is_store, is_mem, misaligned;
  logic         start, ack_hit, timeout_hit;
  logic [3:0]   sel_c;
  logic [31:0]  wrep_c;
  logic [7:0]   op_q;
  logic [1:0]   addr_lo_q;
  logic [31:0]  load_q;

  // Extract the addressed lane (big-endian) and extend it per load type.
  function automatic logic [31:0] fmt_load(input logic [7:0]  op,
                                           input logic [1:0]  lo,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    case (lo)
      2'b00:   b = rd[31:24];
      2'b01:   b = rd[23:16];
      2'b10:   b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = lo[1] ? rd[15:0] : rd[31:16];
    case (op)
      `EXE_LB_OP:  r = {{24{b[7]}}, b};
      `EXE_LBU_OP: r = {24'h000000, b};
      `EXE_LH_OP:  r = {{16{h[15]}}, h};
      `EXE_LHU_OP: r = {16'h0000, h};
      `EXE_LW_OP:  r = rd;
      default:     r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Decode access size/direction, alignment, lane enables and store replication.
  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_store = 1'b0;
    case (aluop_i)
      `EXE_LB_OP, `EXE_LBU_OP: is_byte = 1'b1;
      `EXE_LH_OP, `EXE_LHU_OP: is_half = 1'b1;
      `EXE_LW_OP:              is_word = 1'b1;
      `EXE_SB_OP: begin is_byte = 1'b1; is_store = 1'b1; end
      `EXE_SH_OP: begin is_half = 1'b1; is_store = 1'b1; end
      `EXE_SW_OP: begin is_word = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
    is_mem     = is_byte | is_half | is_word;
    misaligned = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
    sel_c  = 4'b0000;
    wrep_c = reg2_i;
    if (is_byte) begin
      sel_c  = 4'b1000 >> mem_addr_i[1:0];
      wrep_c = {4{reg2_i[7:0]}};
    end else if (is_half) begin
      sel_c  = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      wrep_c = {2{reg2_i[15:0]}};
    end else if (is_word) begin
      sel_c  = 4'b1111;
    end
  end

  assign ack_hit = (state == BUSY) && bus_ack_i;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  assign timeout_hit = (state == BUSY) && !bus_ack_i &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // BUSY-cycle counter and one-cycle abort pulse (ack on the same edge wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= timeout_hit;
      if (start)
        cnt <= '0;
      else if (state == BUSY)
        cnt <= cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state and pipeline-facing outputs.
  always_comb begin
    state_n    = state;
    start      = 1'b0;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          wreg_o = 1'b0;
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            start   = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        wreg_o  = 1'b0;
        if (ack_hit || timeout_hit) state_n = DONE;
      end
      DONE: begin
        wreg_o  = wreg_i & ~bus_we_o & ~bus_err_o;
        wdata_o = load_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus request registers and captured load value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0000_0000;
      bus_sel_o   <= 4'b0000;
      bus_wdata_o <= 32'h0000_0000;
      op_q        <= 8'h00;
      addr_lo_q   <= 2'b00;
      load_q      <= 32'h0000_0000;
    end else begin
      if (start) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= is_store;
        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
        bus_sel_o   <= sel_c;
        bus_wdata_o <= wrep_c;
        op_q        <= aluop_i;
        addr_lo_q   <= mem_addr_i[1:0];
      end else if (ack_hit || timeout_hit) begin
        bus_req_o   <= 1'b0;
      end
      if (ack_hit)
        load_q <= bus_we_o ? 32'h0000_0000 : fmt_load(op_q, addr_lo_q, bus_rdata_i);
      else if (timeout_hit)
        load_q <= 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access.
// Build with MEM_TIMEOUT_EN defined to exercise the timeout abort (TIMEOUT_CYCLES=4).

`ifndef MEM_ACCESS_DEFS
`define MEM_ACCESS_DEFS
`define AluOpBus    7:0
`define RegBus      31:0
`define RegAddrBus  4:0
`define EXE_NOP_OP  8'b00000000
`define EXE_ADD_OP  8'b00100000
`define EXE_LB_OP   8'b11100000
`define EXE_LH_OP   8'b11100001
`define EXE_LW_OP   8'b11100011
`define EXE_LBU_OP  8'b11100100
`define EXE_LHU_OP  8'b11100101
`define EXE_SB_OP   8'b11101000
`define EXE_SH_OP   8'b11101001
`define EXE_SW_OP   8'b11101011
`endif

module tb_mem_access;

  logic        clk, rst;
  logic [7:0]  aluop;
  logic [31:0] mem_addr, reg2, wdata_in;
  logic [4:0]  wd_in;
  logic        wreg_in;
  logic [4:0]  wd_out;
  logic        wreg_out;
  logic [31:0] wdata_out;
  logic        stall, misalign, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2),
    .wd_i(wd_in), .wreg_i(wreg_in), .wdata_i(wdata_in),
    .wd_o(wd_out), .wreg_o(wreg_out), .wdata_o(wdata_out),
    .stall_o(stall), .misalign_o(misalign),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_sel_o(bus_sel), .bus_wdata_o(bus_wdata),
    .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] r2, input logic [31:0] wdat,
                       input logic [4:0] wd, input logic wr);
    aluop    = op;
    mem_addr = addr;
    reg2     = r2;
    wdata_in = wdat;
    wd_in    = wd;
    wreg_in  = wr;
    #1;
  endtask

  task automatic test_reset();
    checks++; if (stall !== 1'b0)        begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
    checks++; if (bus_req !== 1'b0)      begin errors++; $display("FAIL reset_req: got %b exp 0", bus_req); end
    checks++; if (bus_we !== 1'b0)       begin errors++; $display("FAIL reset_we: got %b exp 0", bus_we); end
    checks++; if (misalign !== 1'b0)     begin errors++; $display("FAIL reset_misalign: got %b exp 0", misalign); end
    checks++; if (bus_err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b exp 0", bus_err); end
    checks++; if (bus_addr !== 32'h0)    begin errors++; $display("FAIL reset_addr: got %h exp 0", bus_addr); end
    checks++; if (bus_wdata !== 32'h0)   begin errors++; $display("FAIL reset_wdata: got %h exp 0", bus_wdata); end
    checks++; if (bus_sel !== 4'b0000)   begin errors++; $display("FAIL reset_sel: got %b exp 0000", bus_sel); end
  endtask

  task automatic test_lw();
    int stall_cnt;
    stall_cnt = 0;
    step();
    drive(`EXE_LW_OP, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1);
    if (stall === 1'b1) stall_cnt++;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL lw_req_idle: got %b exp 0", bus_req); end
    step();
    if (stall === 1'b1) stall_cnt++;
    checks++; if (bus_req !== 1'b1)       begin errors++; $display("FAIL lw_req_busy: got %b exp 1", bus_req); end
    checks++; if (bus_sel !== 4'b1111)    begin errors++; $display("FAIL lw_sel: got %b exp 1111", bus_sel); end
    checks++; if (bus_addr !== 32'h100)   begin errors++; $display("FAIL lw_addr: got %h exp 00000100", bus_addr); end
    checks++; if (bus_we !== 1'b0)        begin errors++; $display("FAIL lw_we: got %b exp 0", bus_we); end
    step();
    if (stall === 1'b1) stall_cnt++;
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    step();
    bus_ack = 1'b0;
    if (stall === 1'b1) stall_cnt++;
    checks++; if (stall_cnt !== 3)            begin errors++; $display("FAIL lw_stall_cycles: got %0d exp 3", stall_cnt); end
    checks++; if (wdata_out !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wdata: got %h exp deadbeef", wdata_out); end
    checks++; if (wreg_out !== 1'b1)          begin errors++; $display("FAIL lw_wreg: got %b exp 1", wreg_out); end
    checks++; if (wd_out !== 5'd3)            begin errors++; $display("FAIL lw_wd: got %0d exp 3", wd_out); end
    checks++; if (bus_req !== 1'b0)           begin errors++; $display("FAIL lw_req_done: got %b exp 0", bus_req); end
    step();
    drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_byte_loads();
    logic [7:0]  ops [2];
    logic [31:0] exp [2];
    ops[0] = `EXE_LB_OP;  exp[0] = 32'hFFFFFFF0;
    ops[1] = `EXE_LBU_OP; exp[1] = 32'h000000F0;
    for (int i = 0; i < 2; i++) begin
      step();
      drive(ops[i], 32'h103, 32'h0, 32'h0, 5'd4, 1'b1);
      step();
      checks++; if (bus_sel !== 4'b0001) begin errors++; $display("FAIL byte_sel[%0d]: got %b exp 0001", i, bus_sel); end
      bus_ack   = 1'b1;
      bus_rdata = 32'h123456F0;
      step();
      bus_ack = 1'b0;
      checks++; if (wdata_out !== exp[i]) begin errors++; $display("FAIL byte_wdata[%0d]: got %h exp %h", i, wdata_out, exp[i]); end
      checks++; if (stall !== 1'b0)       begin errors++; $display("FAIL byte_stall_done[%0d]: got %b exp 0", i, stall); end
      step();
      drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    end
  endtask

  task automatic test_store_half();
    step();
    drive(`EXE_SH_OP, 32'h202, 32'h0000ABCD, 32'h0, 5'd6, 1'b1);
    step();
    checks++; if (bus_we !== 1'b1)           begin errors++; $display("FAIL sh_we: got %b exp 1", bus_we); end
    checks++; if (bus_addr !== 32'h200)      begin errors++; $display("FAIL sh_addr: got %h exp 00000200", bus_addr); end
    checks++; if (bus_sel !== 4'b0011)       begin errors++; $display("FAIL sh_sel: got %b exp 0011", bus_sel); end
    checks++; if (bus_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h exp abcdabcd", bus_wdata); end
    bus_ack   = 1'b1;
    bus_rdata = 32'h55555555;
    step();
    bus_ack = 1'b0;
    checks++; if (wreg_out !== 1'b0) begin errors++; $display("FAIL sh_wreg_done: got %b exp 0", wreg_out); end
    checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL sh_stall_done: got %b exp 0", stall); end
    step();
    drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_misalign();
    step();
    drive(`EXE_LW_OP, 32'h101, 32'h0, 32'h0, 5'd2, 1'b1);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b exp 1", misalign); end
    checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL mis_stall: got %b exp 0", stall); end
    checks++; if (wreg_out !== 1'b0) begin errors++; $display("FAIL mis_wreg: got %b exp 0", wreg_out); end
    step();
    drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    checks++; if (bus_req !== 1'b0)  begin errors++; $display("FAIL mis_req: got %b exp 0", bus_req); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b exp 0", misalign); end
  endtask

  task automatic test_passthrough();
    step();
    drive(`EXE_ADD_OP, 32'h0, 32'h0, 32'd5, 5'd7, 1'b1);
    checks++; if (wdata_out !== 32'd5) begin errors++; $display("FAIL add_wdata: got %h exp 5", wdata_out); end
    checks++; if (wd_out !== 5'd7)     begin errors++; $display("FAIL add_wd: got %0d exp 7", wd_out); end
    checks++; if (wreg_out !== 1'b1)   begin errors++; $display("FAIL add_wreg: got %b exp 1", wreg_out); end
    checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL add_stall: got %b exp 0", stall); end
    // stray ack while idle must not start anything
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    checks++; if (bus_req !== 1'b0)    begin errors++; $display("FAIL idle_ack_req: got %b exp 0", bus_req); end
    drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_reset_busy();
    step();
    drive(`EXE_SW_OP, 32'h340, 32'h11223344, 32'h0, 5'd1, 1'b0);
    step();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rb_req_before: got %b exp 1", bus_req); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0)    begin errors++; $display("FAIL rb_req_async: got %b exp 0", bus_req); end
    checks++; if (bus_addr !== 32'h0)  begin errors++; $display("FAIL rb_addr: got %h exp 0", bus_addr); end
    drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL rb_idle_stall: got %b exp 0", stall); end
    @(negedge clk);
    rst = 1'b1;
    // a fresh access after reset starts from IDLE
    step();
    drive(`EXE_LHU_OP, 32'h402, 32'h0, 32'h0, 5'd9, 1'b1);
    step();
    checks++; if (bus_sel !== 4'b0011) begin errors++; $display("FAIL rb_lhu_sel: got %b exp 0011", bus_sel); end
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234F00D;
    step();
    bus_ack = 1'b0;
    checks++; if (wdata_out !== 32'h0000F00D) begin errors++; $display("FAIL rb_lhu_wdata: got %h exp 0000f00d", wdata_out); end
    step();
    drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    step();
    drive(`EXE_LW_OP, 32'h500, 32'h0, 32'h0, 5'd8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL to_req[%0d]: got %b exp 1", i, bus_req); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_err_early[%0d]: got %b exp 0", i, bus_err); end
    end
    step();
    checks++; if (bus_err !== 1'b1)  begin errors++; $display("FAIL to_err: got %b exp 1", bus_err); end
    checks++; if (bus_req !== 1'b0)  begin errors++; $display("FAIL to_req_drop: got %b exp 0", bus_req); end
    checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL to_stall: got %b exp 0", stall); end
    checks++; if (wreg_out !== 1'b0) begin errors++; $display("FAIL to_wreg: got %b exp 0", wreg_out); end
    step();
    drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    checks++; if (bus_err !== 1'b0)  begin errors++; $display("FAIL to_err_pulse: got %b exp 0", bus_err); end
  endtask
`else
  task automatic test_no_timeout();
    step();
    drive(`EXE_LW_OP, 32'h500, 32'h0, 32'h0, 5'd8, 1'b1);
    repeat (20) step();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL nto_req: got %b exp 1", bus_req); end
    checks++; if (stall !== 1'b1)   begin errors++; $display("FAIL nto_stall: got %b exp 1", stall); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL nto_err: got %b exp 0", bus_err); end
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE0001;
    step();
    bus_ack = 1'b0;
    checks++; if (wdata_out !== 32'hCAFE0001) begin errors++; $display("FAIL nto_wdata: got %h exp cafe0001", wdata_out); end
    step();
    drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask
`endif

  initial begin
    clk       = 1'b0;
    rst       = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    drive(`EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_lw();
    test_byte_loads();
    test_store_half();
    test_misalign();
    test_passthrough();
    test_reset_busy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage load/store engine. Consumes the memory request the execute stage forwards: aluop, effective address and store data.
- Runs a req/ack transaction on the data bus and formats load data with sign or zero extension.
- Stalls the pipeline while the access is outstanding.
- Non-memory instructions pass through combinationally with zero added latency.

Parameters:
- TIMEOUT_CYCLES, 16: BUSY cycles without ack before abort. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous reset, active-low
- aluop_i  input  `AluOpBus  operation from EX/MEM register
- mem_addr_i  input  `RegBus  effective byte address
- reg2_i  input  `RegBus  store data
- wd_i  input  `RegAddrBus  destination register
- wreg_i  input  1  register write enable from EX
- wdata_i  input  `RegBus  EX result for non-load instructions
- wd_o  output  `RegAddrBus  destination to MEM/WB
- wreg_o  output  1  write enable to MEM/WB
- wdata_o  output  `RegBus  result to MEM/WB
- stall_o  output  1  stall request to pipeline control
- misalign_o  output  1  address misaligned, one-cycle pulse
- bus_req_o  output  1  bus request
- bus_we_o  output  1  1 = write
- bus_addr_o  output  `RegBus  word address, bits [1:0] forced to 00
- bus_sel_o  output  4  byte lane enables
- bus_wdata_o  output  `RegBus  lane-replicated store data
- bus_rdata_i  input  `RegBus  read data
- bus_ack_i  input  1  transfer complete
- bus_err_o  output  1  timeout abort pulse; always 0 without the option

Behaviour:
- Memory ops: `EXE_LB_OP, `EXE_LBU_OP, `EXE_LH_OP, `EXE_LHU_OP, `EXE_LW_OP, `EXE_SB_OP, `EXE_SH_OP, `EXE_SW_OP. All other aluop values are non-memory.
- FSM states: IDLE, BUSY, DONE. Asynchronous reset (rst=0) forces IDLE from any state, including mid-transaction.
- Reset values:
  - stall_o, bus_req_o, bus_we_o, misalign_o, bus_err_o = 0
  - bus_addr_o, bus_wdata_o, internal load register = 0
  - bus_sel_o = 4'b0000
- IDLE, non-memory op:
  - wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i combinationally.
  - stall_o=0.
- IDLE, memory op, misaligned:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠00.
  - No bus cycle is issued. misalign_o=1 and wreg_o=0 combinationally, stall_o=0, FSM stays IDLE.
- IDLE, memory op, aligned:
  - stall_o=1 combinationally.
  - On the next edge: go to BUSY; latch address, op, sel and wdata into bus registers.
- Lane mapping is big-endian:
  - byte: addr[1:0] 00/01/10/11 -> sel 1000/0100/0010/0001
  - half: addr[1]=0 -> 1100, addr[1]=1 -> 0011
  - word: 1111
  - Store data is replicated: byte {4{b}}, half {2{h}}, word as-is.
- BUSY:
  - bus_req_o=1 and stall_o=1.
  - Address, sel, we and wdata stay stable until ack.
  - On bus_ack_i=1: capture the formatted load value (stores capture 0) and go to DONE. bus_req_o drops in the same edge.
- Load formatting: extract the selected lane. LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
- DONE:
  - stall_o=0 for exactly one cycle.
  - Load: wreg_o=wreg_i, wdata_o=captured value.
  - Store: wreg_o=0.
  - wd_o=wd_i. Next state is IDLE.
- Pipeline control holds EX/MEM inputs stable while stall_o=1. The block does not re-sample aluop_i in BUSY.
- Access latency: 1 cycle (IDLE->BUSY) + N ack-wait cycles + 1 DONE cycle. Minimum total is 3 cycles, with ack on the first BUSY cycle.
- bus_ack_i outside BUSY is ignored.
- A memory op arriving in DONE is not started until the following IDLE cycle; the pipeline has advanced by then.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES with no ack: drop bus_req_o, pulse bus_err_o for 1 cycle, go to DONE with wreg_o=0.
  - An ack on the same edge as the timeout wins.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o is tied 0.

Test Plan:
- LW at addr 0x100, bus acks after 2 BUSY cycles with 0xDEADBEEF -> bus_sel_o=1111, stall_o high 3 cycles, DONE cycle wdata_o=0xDEADBEEF, wreg_o=1.
- LB at 0x103, rdata 0x123456F0 -> sel 0001, wdata_o=0xFFFFFFF0. Repeat with LBU -> 0x000000F0.
- SH at 0x202, reg2_i=0x0000ABCD -> bus_we_o=1, bus_addr_o=0x200, sel 0011, bus_wdata_o=0xABCDABCD, DONE wreg_o=0.
- LW at 0x101 -> misalign_o=1 one cycle, no bus_req_o, stall_o=0, wreg_o=0.
- ADD passthrough, wdata_i=5 -> wdata_o=5 same cycle, stall_o=0. Reset asserted during BUSY -> bus_req_o=0 immediately, FSM IDLE.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, ack never asserted -> bus_err_o pulses after 4 BUSY cycles, then stall_o=0.
